// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester ports, memory-side signals and FSM state of the memory arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int A = 12,
  parameter int D = 16
);
  // Handshake: a requester raises req with we/addr/wdata stable and holds them
  // until done; gnt pulses once when the request is taken, done pulses once when
  // the access is complete and rdata is valid only in that done cycle.
  logic         p0_req;
  logic         p0_we;
  logic [A-1:0] p0_addr;
  logic [D-1:0] p0_wdata;
  logic         p0_gnt;
  logic         p0_done;
  logic [D-1:0] p0_rdata;

  logic         p1_req;
  logic         p1_we;
  logic [A-1:0] p1_addr;
  logic [D-1:0] p1_wdata;
  logic         p1_gnt;
  logic         p1_done;
  logic [D-1:0] p1_rdata;

  logic [A-1:0] mem_address;
  logic         mem_write_enable;
  logic [D-1:0] mem_input_data;
  logic [D-1:0] mem_output_data;

  state_t       state;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_output_data,
    output p0_gnt, p0_done, p0_rdata,
    output p1_gnt, p1_done, p1_rdata,
    output mem_address, mem_write_enable, mem_input_data,
    output state
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_output_data,
    input  p0_gnt, p0_done, p0_rdata,
    input  p1_gnt, p1_done, p1_rdata,
    input  mem_address, mem_write_enable, mem_input_data,
    input  state
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way winner select: round-robin against last_grant or fixed port-0 priority.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed,
  output logic       any,
  output logic       win
);
  always_comb begin
    any = |req;
    win = PORT0;
    if (req == 2'b11) begin
      win = fixed ? PORT0 : ~last_grant;
    end else if (req[1]) begin
      win = PORT1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer sharing one single-port synchronous memory between two requesters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int A        = 12,
  parameter int D        = 16,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam logic FIXED = (ARB_MODE == ARB_FIXED);

  state_t       state, state_n;
  logic         win_q, win_n;
  logic         last_grant, last_grant_n;
  logic [A-1:0] addr_q, addr_n;
  logic [D-1:0] data_q, data_n;
  logic         we_q, we_n;
  logic [1:0]   gnt_q, gnt_n;
  logic [1:0]   done_q, done_n;
  logic         any;
  logic         win;

  rr_pick2 u_pick (
    .req        ({bus.p1_req, bus.p0_req}),
    .last_grant (last_grant),
    .fixed      (FIXED),
    .any        (any),
    .win        (win)
  );

  always_comb begin
    state_n      = state;
    win_n        = win_q;
    last_grant_n = last_grant;
    addr_n       = addr_q;
    data_n       = data_q;
    we_n         = 1'b0;
    gnt_n        = 2'b00;
    done_n       = 2'b00;
    case (state)
      IDLE: begin
        if (any) begin
          win_n        = win;
          last_grant_n = win;
          gnt_n[win]   = 1'b1;
          state_n      = ACCESS;
          if (win == PORT1) begin
            addr_n = bus.p1_addr;
            data_n = bus.p1_wdata;
            we_n   = bus.p1_we;
          end else begin
            addr_n = bus.p0_addr;
            data_n = bus.p0_wdata;
            we_n   = bus.p0_we;
          end
        end
      end
      ACCESS: begin
        // Memory samples at the edge closing this cycle; its output is valid in RESP.
        done_n[win_q] = 1'b1;
        state_n       = RESP;
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      win_q      <= PORT0;
      last_grant <= PORT1;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
    end else begin
      state      <= state_n;
      win_q      <= win_n;
      last_grant <= last_grant_n;
      addr_q     <= addr_n;
      data_q     <= data_n;
      we_q       <= we_n;
      gnt_q      <= gnt_n;
      done_q     <= done_n;
    end
  end

  assign bus.mem_address      = addr_q;
  assign bus.mem_write_enable = we_q;
  assign bus.mem_input_data   = data_q;
  assign bus.p0_gnt           = gnt_q[0];
  assign bus.p1_gnt           = gnt_q[1];
  assign bus.p0_done          = done_q[0];
  assign bus.p1_done          = done_q[1];
  assign bus.p0_rdata         = bus.mem_output_data;
  assign bus.p1_rdata         = bus.mem_output_data;
  assign bus.state            = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances, each on a behavioural memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int A = 12;
  localparam int D = 16;
  localparam int W = D + 1;

  typedef struct {
    logic         port;
    logic         we;
    logic [A-1:0] addr;
    logic [D-1:0] wdata;
    logic [D-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_got, mon_exp;

  mem_arbiter_if #(.A(A), .D(D)) bus1 ();
  mem_arbiter_if #(.A(A), .D(D)) bus2 ();

  mem_arbiter #(.A(A), .D(D), .ARB_MODE(ARB_RR)) dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (bus1)
  );

  mem_arbiter #(.A(A), .D(D), .ARB_MODE(ARB_FIXED)) dut2 (
    .clock (clk),
    .reset (rst),
    .bus   (bus2)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  // behavioural memories: read-before-write, one-cycle registered output
  logic [D-1:0] mem1 [0:(1<<A)-1];
  logic [D-1:0] mem2 [0:(1<<A)-1];
  logic         pre_we = 1'b0;
  logic [A-1:0] pre_addr = '0;
  logic [D-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) begin
      mem1[pre_addr] <= pre_data;
    end else begin
      bus1.mem_output_data <= mem1[bus1.mem_address];
      if (bus1.mem_write_enable) mem1[bus1.mem_address] <= bus1.mem_input_data;
    end
  end

  always @(posedge clk) begin
    bus2.mem_output_data <= mem2[bus2.mem_address];
    if (bus2.mem_write_enable) mem2[bus2.mem_address] <= bus2.mem_input_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every done on dut1 pops one {port, rdata} expectation
  always @(negedge clk) begin
    if (bus1.p0_done || bus1.p1_done) begin
      check("done_onehot", 32'(bus1.p0_done & bus1.p1_done), 32'd0);
      mon_got = {bus1.p1_done, (bus1.p1_done ? bus1.p1_rdata : bus1.p0_rdata)};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got %h required no done", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("done_data", 32'(mon_got), 32'(mon_exp));
      end
    end
    if (bus1.mem_write_enable)
      check("we_only_in_access", 32'(bus1.p0_gnt | bus1.p1_gnt), 32'd1);
  end

  // driver tasks
  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [A-1:0] addr, input logic [D-1:0] wdata);
    if (port == PORT1) begin
      bus1.p1_req = req; bus1.p1_we = we; bus1.p1_addr = addr; bus1.p1_wdata = wdata;
    end else begin
      bus1.p0_req = req; bus1.p0_we = we; bus1.p0_addr = addr; bus1.p0_wdata = wdata;
    end
  endtask

  task automatic txn(input logic port, input logic we, input logic [A-1:0] addr,
                     input logic [D-1:0] wdata, input logic [D-1:0] exp);
    logic [1:0] onehot;
    onehot = (port == PORT1) ? 2'b10 : 2'b01;
    @(negedge clk);
    exp_q.push_back({port, exp});
    drive(port, 1'b1, we, addr, wdata);
    @(negedge clk);
    check("gnt", 32'({bus1.p1_gnt, bus1.p0_gnt}), 32'(onehot));
    check("mem_address", 32'(bus1.mem_address), 32'(addr));
    check("mem_we_access", 32'(bus1.mem_write_enable), 32'(we));
    if (we) check("mem_input_data", 32'(bus1.mem_input_data), 32'(wdata));
    check("no_done_at_gnt", 32'({bus1.p1_done, bus1.p0_done}), 32'd0);
    @(negedge clk);
    check("done", 32'({bus1.p1_done, bus1.p0_done}), 32'(onehot));
    check("gnt_low_resp", 32'({bus1.p1_gnt, bus1.p0_gnt}), 32'd0);
    check("mem_we_resp", 32'(bus1.mem_write_enable), 32'd0);
    drive(port, 1'b0, we, addr, wdata);
  endtask

  vec_t vecs[8];
  int   cyc, n;
  logic [1:0] prev_oh;

  initial begin
    bus1.p0_req = 0; bus1.p0_we = 0; bus1.p0_addr = '0; bus1.p0_wdata = '0;
    bus1.p1_req = 0; bus1.p1_we = 0; bus1.p1_addr = '0; bus1.p1_wdata = '0;
    bus2.p0_req = 0; bus2.p0_we = 0; bus2.p0_addr = '0; bus2.p0_wdata = '0;
    bus2.p1_req = 0; bus2.p1_we = 0; bus2.p1_addr = '0; bus2.p1_wdata = '0;

    vecs[0] = '{PORT0, 1'b0, 12'h010, 16'h0000, 16'hABCD};
    vecs[1] = '{PORT1, 1'b1, 12'hFFF, 16'h1234, 16'h0F0F};
    vecs[2] = '{PORT1, 1'b0, 12'hFFF, 16'h0000, 16'h1234};
    vecs[3] = '{PORT0, 1'b1, 12'h000, 16'hBEEF, 16'h1111};
    vecs[4] = '{PORT0, 1'b0, 12'h000, 16'h0000, 16'hBEEF};
    vecs[5] = '{PORT1, 1'b0, 12'h010, 16'h0000, 16'hABCD};
    vecs[6] = '{PORT1, 1'b1, 12'h800, 16'h7777, 16'h2222};
    vecs[7] = '{PORT0, 1'b0, 12'h800, 16'h0000, 16'h7777};

    // preload under reset
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      case (i)
        0: begin pre_addr = 12'h010; pre_data = 16'hABCD; end
        1: begin pre_addr = 12'hFFF; pre_data = 16'h0F0F; end
        2: begin pre_addr = 12'h000; pre_data = 16'h1111; end
        3: begin pre_addr = 12'h800; pre_data = 16'h2222; end
        4: begin pre_addr = 12'h020; pre_data = 16'h0000; end
        default: begin pre_addr = 12'h030; pre_data = 16'h3333; end
      endcase
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(bus1.state), 32'(IDLE));
    check("rst_gnt", 32'({bus1.p1_gnt, bus1.p0_gnt}), 32'd0);
    check("rst_done", 32'({bus1.p1_done, bus1.p0_done}), 32'd0);
    check("rst_mem_we", 32'(bus1.mem_write_enable), 32'd0);
    check("rst_mem_address", 32'(bus1.mem_address), 32'd0);
    check("rst_mem_input_data", 32'(bus1.mem_input_data), 32'd0);
    rst = 1'b0;

    // table-driven single transactions with random idle gaps
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    end

    // reset while a p0 write is in ACCESS: write lands, no done
    @(negedge clk);
    drive(PORT0, 1'b1, 1'b1, 12'h020, 16'h5555);
    @(negedge clk);
    check("rsta_gnt", 32'(bus1.p0_gnt), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rsta_no_done", 32'({bus1.p1_done, bus1.p0_done}), 32'd0);
    check("rsta_state", 32'(bus1.state), 32'(IDLE));
    rst = 1'b0;
    drive(PORT0, 1'b0, 1'b0, 12'h020, 16'h0000);
    txn(PORT0, 1'b0, 12'h020, 16'h0000, 16'h5555);

    // back-to-back: new p0 request presented in the done cycle
    @(negedge clk);
    exp_q.push_back({PORT0, 16'hABCD});
    drive(PORT0, 1'b1, 1'b0, 12'h010, 16'h0000);
    @(negedge clk);
    check("b2b_gnt1", 32'(bus1.p0_gnt), 32'd1);
    @(negedge clk);
    check("b2b_done1", 32'(bus1.p0_done), 32'd1);
    exp_q.push_back({PORT0, 16'h3333});
    drive(PORT0, 1'b1, 1'b1, 12'h030, 16'h0A0A);
    @(negedge clk);
    check("b2b_idle_gnt", 32'({bus1.p1_gnt, bus1.p0_gnt}), 32'd0);
    check("b2b_idle_we", 32'(bus1.mem_write_enable), 32'd0);
    @(negedge clk);
    check("b2b_gnt2", 32'(bus1.p0_gnt), 32'd1);
    check("b2b_we2", 32'(bus1.mem_write_enable), 32'd1);
    check("b2b_addr2", 32'(bus1.mem_address), 32'h030);
    @(negedge clk);
    check("b2b_done2", 32'(bus1.p0_done), 32'd1);
    check("b2b_we_low", 32'(bus1.mem_write_enable), 32'd0);
    drive(PORT0, 1'b0, 1'b0, 12'h030, 16'h0000);
    txn(PORT0, 1'b0, 12'h030, 16'h0000, 16'h0A0A);

    // round-robin contention with both requests held from reset
    @(negedge clk);
    rst = 1'b1;
    drive(PORT0, 1'b1, 1'b0, 12'h010, 16'h0000);
    drive(PORT1, 1'b1, 1'b0, 12'h800, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; n = 0; prev_oh = 2'b00;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (n > 0 && cyc == 3 * n - 1)
        check("rr_done", 32'({bus1.p1_done, bus1.p0_done}), 32'(prev_oh));
      if (bus1.p0_gnt || bus1.p1_gnt) begin
        check("rr_port", 32'(bus1.p1_gnt), 32'(n % 2));
        check("rr_cycle", 32'(cyc), 32'(1 + 3 * n));
        exp_q.push_back((n % 2 == 1) ? {1'b1, 16'h7777} : {1'b0, 16'hABCD});
        prev_oh = (n % 2 == 1) ? 2'b10 : 2'b01;
        if (n == 3) bus1.p0_req = 1'b0;
        n++;
      end
    end
    check("rr_grants_seen", 32'(n), 32'd4);
    @(negedge clk);
    check("rr_last_done", 32'({bus1.p1_done, bus1.p0_done}), 32'b10);
    bus1.p1_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rr_quiet", 32'({bus1.p1_gnt, bus1.p0_gnt}), 32'd0);
    end

    // fixed priority: p0 wins while held; p1 served after p0 drops
    @(negedge clk);
    bus2.p0_req = 1'b1; bus2.p0_addr = 12'h001;
    bus2.p1_req = 1'b1; bus2.p1_addr = 12'h002;
    cyc = 0; n = 0; prev_oh = 2'b00;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (n > 0 && cyc == 3 * n - 1)
        check("fx_done", 32'({bus2.p1_done, bus2.p0_done}), 32'(prev_oh));
      if (bus2.p0_gnt || bus2.p1_gnt) begin
        check("fx_port", 32'(bus2.p1_gnt), (n == 3) ? 32'd1 : 32'd0);
        check("fx_cycle", 32'(cyc), 32'(1 + 3 * n));
        prev_oh = (n == 3) ? 2'b10 : 2'b01;
        if (n == 2) bus2.p0_req = 1'b0;
        n++;
      end
    end
    check("fx_grants_seen", 32'(n), 32'd4);
    @(negedge clk);
    check("fx_last_done", 32'({bus2.p1_done, bus2.p0_done}), 32'b10);
    bus2.p1_req = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
